// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_e : arbiter FSM states (StIdle, StLock, StDrain)
//   UART_DAT_W  : byte width on every requester and on the TX core interface
//   clog2_min1  : ceil(log2(n)) with a floor of 1, for index widths
package uart_arb_pkg;

  localparam int unsigned UART_DAT_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLock,
    StDrain
  } arb_state_e;

  // An index into a 1- or 2-entry vector still needs one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational requester picker for the UART transmit arbiter.
// Default build: round-robin, searching upward from last_grant+1 and wrapping.
// With UART_TX_ARB_PRIO_EN defined: strict priority, lowest index wins, and
// last_grant is ignored.
// Ports:
//   req        in   NUM_REQ  request vector
//   last_grant in   GNT_W    most recently served requester
//   pick       out  GNT_W    chosen requester (valid when any=1)
//   any        out  1        at least one request is set
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned GNT_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GNT_W-1:0]   last_grant,
  output logic [GNT_W-1:0]   pick,
  output logic               any
);

  assign any = |req;

`ifdef UART_TX_ARB_PRIO_EN

  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    pick = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[i]) pick = GNT_W'(i);
    end
  end

`else

  // Requests strictly above last_grant take precedence; if there are none the
  // search wraps around to the lowest set request.
  logic [NUM_REQ-1:0] hi_req;

  always_comb begin
    hi_req = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      hi_req[i] = req[i] && (i > 32'(last_grant));
    end
  end

  always_comb begin
    pick = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[i]) pick = GNT_W'(i);
    end
    if (|hi_req) begin
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
        if (hi_req[i]) pick = GNT_W'(i);
      end
    end
  end

`endif

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-locked arbiter sharing one UART transmitter among NUM_REQ byte-stream
// requesters. A grant is held until the requester's last byte is accepted or
// until it stalls for TIMEOUT cycles mid-packet.
// Optional macro UART_TX_ARB_PRIO_EN: strict-priority arbitration (lowest index)
// instead of round-robin; packet lock and timeout are unchanged.
// Ports:
//   clk       in   1            system clock
//   rst       in   1            synchronous active-high reset
//   req_dat   in   NUM_REQ*8    requester i byte at [8i+7:8i]
//   req_valid in   NUM_REQ      per-requester byte valid
//   req_last  in   NUM_REQ      final byte of packet (qualified by req_valid)
//   req_ready out  NUM_REQ      per-requester accept
//   tx_dat    out  8            byte to UART TX core
//   tx_wr_ev  out  1            write request, held until tx_ready
//   tx_ready  in   1            TX core accepts tx_dat when tx_wr_ev=1
//   grant_id  out  GNT_W        current or last granted requester
//   busy      out  1            arbiter not idle
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 1000000,
  parameter int unsigned GNT_W   = clog2_min1(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*UART_DAT_W-1:0] req_dat,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [UART_DAT_W-1:0]         tx_dat,
  output logic                          tx_wr_ev,
  input  logic                          tx_ready,
  output logic [GNT_W-1:0]              grant_id,
  output logic                          busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  arb_state_e            state_q, state_d;
  logic [GNT_W-1:0]      grant_q, grant_d;
  logic [GNT_W-1:0]      last_q, last_d;
  logic [UART_DAT_W-1:0] dat_q, dat_d;
  logic                  wr_q, wr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic [GNT_W-1:0]      pick_idx;
  logic                  pick_any;

  logic [UART_DAT_W-1:0] dat_sel;
  logic                  vld_g, last_g, rdy_g, in_xfer, out_xfer;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GNT_W   (GNT_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_q),
    .pick       (pick_idx),
    .any        (pick_any)
  );

  // Granted requester's signals and its accept.
  always_comb begin
    dat_sel   = '0;
    vld_g     = 1'b0;
    last_g    = 1'b0;
    req_ready = '0;
    // The holding register frees up in the same cycle the TX core drains it.
    rdy_g     = (state_q == StLock) && (!wr_q || tx_ready);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GNT_W'(i)) begin
        dat_sel      = req_dat[i*UART_DAT_W +: UART_DAT_W];
        vld_g        = req_valid[i];
        last_g       = req_last[i];
        req_ready[i] = rdy_g;
      end
    end
    in_xfer  = rdy_g && vld_g;
    out_xfer = wr_q && tx_ready;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    dat_d   = dat_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = StLock;
        end
      end
      StLock: begin
        if (in_xfer) begin
          // A new byte overrides a simultaneous drain: tx_wr_ev stays high.
          dat_d = dat_sel;
          wr_d  = 1'b1;
          cnt_d = '0;
          if (last_g) state_d = StDrain;
        end else begin
          if (out_xfer) wr_d = 1'b0;
          if (cnt_q >= CntW'(TIMEOUT - 1)) state_d = StDrain;
          if (cnt_q != CntW'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (!wr_q || tx_ready) begin
          wr_d    = 1'b0;
          last_d  = grant_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= GNT_W'(NUM_REQ - 1);
      dat_q   <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      dat_q   <= dat_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tx_dat   = dat_q;
  assign tx_wr_ev = wr_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

  localparam int GW     = 1;
  localparam int BUDGET = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance
  logic [7:0]  rd [2];
  logic        rv [2];
  logic        rl [2];
  logic [15:0] req_dat;
  logic [1:0]  req_valid, req_last, req_ready;
  logic [7:0]  tx_dat;
  logic        tx_wr_ev, tx_ready, busy;
  logic [GW-1:0] grant_id;

  assign req_dat   = {rd[1], rd[0]};
  assign req_valid = {rv[1], rv[0]};
  assign req_last  = {rl[1], rl[0]};

  uart_tx_arb #(.NUM_REQ(2), .TIMEOUT(200)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_dat   (req_dat),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_dat    (tx_dat),
    .tx_wr_ev  (tx_wr_ev),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  // Short-timeout instance
  logic [15:0] req_dat2;
  logic [1:0]  req_valid2, req_last2, req_ready2;
  logic [7:0]  tx_dat2;
  logic        tx_wr_ev2, tx_ready2, busy2;
  logic [GW-1:0] grant_id2;

  uart_tx_arb #(.NUM_REQ(2), .TIMEOUT(16)) dut_to (
    .clk       (clk),
    .rst       (rst),
    .req_dat   (req_dat2),
    .req_valid (req_valid2),
    .req_last  (req_last2),
    .req_ready (req_ready2),
    .tx_dat    (tx_dat2),
    .tx_wr_ev  (tx_wr_ev2),
    .tx_ready  (tx_ready2),
    .grant_id  (grant_id2),
    .busy      (busy2)
  );

  typedef struct {
    int         id;
    logic [7:0] b;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Every output transfer must be the next expected (requester, byte).
  always @(negedge clk) begin
    if (!rst && tx_wr_ev && tx_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got id=%0d byte=%h, required no output", grant_id, tx_dat);
      end else begin
        mon_e = sb.pop_front();
        if (tx_dat !== mon_e.b || grant_id !== GW'(mon_e.id)) begin
          n_fail++;
          $display("FAIL out_byte: got id=%0d byte=%h, required id=%0d byte=%h",
                   grant_id, tx_dat, mon_e.id, mon_e.b);
        end
      end
    end
  end

  task automatic push_pkt(input int r, input string s);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      e.id = r;
      e.b  = s[i];
      sb.push_back(e);
    end
  endtask

  task automatic send_pkt(input int r, input string s, input bit with_last);
    bit acc;
    for (int i = 0; i < s.len(); i++) begin
      rd[r] = s[i];
      rv[r] = 1'b1;
      rl[r] = with_last && (i == s.len() - 1);
      acc = 1'b0;
      for (int c = 0; c < BUDGET && !acc; c++) begin
        @(negedge clk);
        acc = req_ready[r];
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: req%0d byte %0d not accepted, required accept", r, i);
      end
    end
    rv[r] = 1'b0;
    rl[r] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int c = 0; c < BUDGET && !done; c++) begin
      @(negedge clk);
      done = !busy && !tx_wr_ev;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_idle: busy=%b tx_wr_ev=%b, required 0 0", name, busy, tx_wr_ev);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_sb: %0d bytes outstanding, required 0", name, sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (tx_dat !== 8'h00 || tx_wr_ev !== 1'b0 || req_ready !== 2'b00 ||
        grant_id !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: dat=%h wr=%b rdy=%b gnt=%0d busy=%b, required 00 0 00 0 0",
               tx_dat, tx_wr_ev, req_ready, grant_id, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    tx_ready = 1'b1;
    push_pkt(1, "ab");
    send_pkt(1, "ab", 1'b1);
    // Last byte accepted: draining, final output transfer on the next edge.
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || grant_id !== GW'(1) || tx_wr_ev !== 1'b1) begin
      n_fail++;
      $display("FAIL single_drain: busy=%b gnt=%0d wr=%b, required 1 1 1", busy, grant_id, tx_wr_ev);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || tx_wr_ev !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_drop: busy=%b wr=%b, required 0 0", busy, tx_wr_ev);
    end
    wait_idle("single");
  endtask

  task automatic test_rr_two();
    tx_ready = 1'b1;
    push_pkt(0, "xyz");
    push_pkt(1, "pqr");
    fork
      send_pkt(0, "xyz", 1'b1);
      send_pkt(1, "pqr", 1'b1);
    join
    push_pkt(0, "XYZ");
    push_pkt(1, "PQR");
    fork
      send_pkt(0, "XYZ", 1'b1);
      send_pkt(1, "PQR", 1'b1);
    join
    wait_idle("rr_two");
  endtask

  task automatic test_stall();
    tx_ready = 1'b1;
    push_pkt(0, "klm");
    fork
      send_pkt(0, "klm", 1'b1);
      begin
        bit seen = 1'b0;
        for (int c = 0; c < BUDGET && !seen; c++) begin
          @(negedge clk);
          seen = tx_wr_ev;
        end
        // 'k' drains and 'l' is accepted on this edge; 'l' is then held.
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          n_checks++;
          if (!seen || tx_wr_ev !== 1'b1 || tx_dat !== 8'h6c || req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL stall_cyc%0d: wr=%b dat=%h rdy=%b, required 1 6c 00",
                     c, tx_wr_ev, tx_dat, req_ready);
          end
        end
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
      end
    join
    wait_idle("stall");
  endtask

  task automatic test_timeout();
    bit ok = 1'b0;
    tx_ready2  = 1'b1;
    req_dat2   = {8'h22, 8'h11};
    req_last2  = 2'b10;
    req_valid2 = 2'b11;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = req_ready2[0];
      @(posedge clk);
      #1;
    end
    req_valid2[0] = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL to_accept: req0 byte accepted=%b, required 1", ok);
    end
    // 16 idle LOCK cycles plus one DRAIN cycle keep requester 0 granted.
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      n_checks++;
      if (busy2 !== 1'b1 || grant_id2 !== GW'(0) || req_ready2[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL to_hold%0d: busy=%b gnt=%0d rdy1=%b, required 1 0 0",
                 c, busy2, grant_id2, req_ready2[1]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL to_release: busy=%b, required 0", busy2);
    end
    @(negedge clk);
    n_checks++;
    if (busy2 !== 1'b1 || grant_id2 !== GW'(1)) begin
      n_fail++;
      $display("FAIL to_next_grant: busy=%b gnt=%0d, required 1 1", busy2, grant_id2);
    end
    @(negedge clk);
    req_valid2 = 2'b00;
    req_last2  = 2'b00;
    n_checks++;
    if (tx_wr_ev2 !== 1'b1 || tx_dat2 !== 8'h22) begin
      n_fail++;
      $display("FAIL to_next_byte: wr=%b dat=%h, required 1 22", tx_wr_ev2, tx_dat2);
    end
  endtask

  task automatic test_reset_mid();
    bit ok = 1'b0;
    tx_ready = 1'b1;
    push_pkt(0, "no");
    send_pkt(0, "no", 1'b1);
    wait_idle("rst_pre");
    // Leave a byte from requester 1 stuck in the holding register.
    tx_ready = 1'b0;
    rd[1] = 8'h73;
    rl[1] = 1'b0;
    rv[1] = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = req_ready[1];
      @(posedge clk);
      #1;
    end
    rv[1] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!ok || tx_wr_ev !== 1'b1 || tx_dat !== 8'h73 || grant_id !== GW'(1)) begin
      n_fail++;
      $display("FAIL rst_mid_pre: acc=%b wr=%b dat=%h gnt=%0d, required 1 1 73 1",
               ok, tx_wr_ev, tx_dat, grant_id);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tx_dat !== 8'h00 || tx_wr_ev !== 1'b0 || req_ready !== 2'b00 ||
        grant_id !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: dat=%h wr=%b rdy=%b gnt=%0d busy=%b, required 00 0 00 0 0",
               tx_dat, tx_wr_ev, req_ready, grant_id, busy);
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    push_pkt(0, "u");
    push_pkt(1, "v");
    fork
      send_pkt(0, "u", 1'b1);
      send_pkt(1, "v", 1'b1);
    join
    wait_idle("rst_post");
  endtask

  task automatic test_prio();
    tx_ready = 1'b1;
`ifdef UART_TX_ARB_PRIO_EN
    push_pkt(0, "A0");
    push_pkt(0, "B0");
    push_pkt(0, "C0");
    push_pkt(1, "W1");
`else
    push_pkt(0, "A0");
    push_pkt(1, "W1");
    push_pkt(0, "B0");
    push_pkt(0, "C0");
`endif
    fork
      begin
        send_pkt(0, "A0", 1'b1);
        send_pkt(0, "B0", 1'b1);
        send_pkt(0, "C0", 1'b1);
      end
      send_pkt(1, "W1", 1'b1);
    join
    wait_idle("prio");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    tx_ready   = 1'b0;
    rd[0]      = 8'h00;
    rd[1]      = 8'h00;
    rv[0]      = 1'b0;
    rv[1]      = 1'b0;
    rl[0]      = 1'b0;
    rl[1]      = 1'b0;
    req_dat2   = '0;
    req_valid2 = '0;
    req_last2  = '0;
    tx_ready2  = 1'b1;

    test_reset();
    test_single();
    test_rr_two();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_prio();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
